// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Sequences reads from a slow combinational instruction memory and buffers
// {PC, instruction} pairs in a small show-ahead FIFO for the core. Each
// address is held for WAIT_CYCLES clocks before MemData is captured. A
// redirect from the core flushes the FIFO and restarts fetch at a new PC.

module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter int          DEPTH       = 4
) (
  input  logic                     CLK,
  input  logic                     Reset_L,
  output logic [31:0]              MemAddr,
  input  logic [31:0]              MemData,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectPC,
  input  logic                     InstrReady,
  output logic                     InstrValid,
  output logic [31:0]              Instr,
  output logic [31:0]              InstrPC,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef logic [CW-1:0] wcnt_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam wcnt_t WAIT_LAST = wcnt_t'(WAIT_CYCLES - 1);
  localparam cnt_t  FULL      = cnt_t'(DEPTH);

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_r, state_s;
  wcnt_t       wcnt_r, wcnt_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  cnt_t        count_r, count_s;
  ptr_t        rd_ptr_r, rd_ptr_s;
  ptr_t        wr_ptr_r, wr_ptr_s;
  logic        capture_s;
  logic        pop_s;
  logic        valid_s;

  logic [31:0] instr_mem_r [DEPTH];
  logic [31:0] pc_mem_r    [DEPTH];

  // The low two bits of the redirect target are dropped by design.
  logic redirect_lsb_unused_s;
  assign redirect_lsb_unused_s = ^RedirectPC[1:0];

  assign valid_s    = (count_r != cnt_t'(0));
  assign MemAddr    = fetch_pc_r;
  assign Count      = count_r;
  assign InstrValid = valid_s;

  // Next-state logic: redirect overrides everything, then access sequencing and pop.
  always_comb begin
    state_s    = state_r;
    wcnt_s     = wcnt_r;
    fetch_pc_s = fetch_pc_r;
    count_s    = count_r;
    rd_ptr_s   = rd_ptr_r;
    wr_ptr_s   = wr_ptr_r;
    capture_s  = 1'b0;
    pop_s      = 1'b0;

    if (Redirect) begin
      // Abort the in-flight access and drop both FIFO contents and any pop.
      state_s    = ST_WAIT;
      wcnt_s     = wcnt_t'(0);
      fetch_pc_s = {RedirectPC[31:2], 2'b00};
      count_s    = cnt_t'(0);
      rd_ptr_s   = ptr_t'(0);
      wr_ptr_s   = ptr_t'(0);
    end else begin
      pop_s = valid_s & InstrReady;

      case (state_r)
        ST_WAIT: begin
          if (wcnt_r == WAIT_LAST) begin
            capture_s  = 1'b1;
            wcnt_s     = wcnt_t'(0);
            fetch_pc_s = fetch_pc_r + 32'd4;
          end else begin
            wcnt_s = wcnt_r + wcnt_t'(1);
          end
        end
        ST_HOLD: begin
          if (pop_s) begin
            state_s = ST_WAIT;
            wcnt_s  = wcnt_t'(0);
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s = ST_WAIT;
          wcnt_s  = wcnt_t'(0);
        end
      endcase

      count_s = count_r + cnt_t'(capture_s) - cnt_t'(pop_s);

      if (capture_s) begin
        wr_ptr_s = wr_ptr_r + ptr_t'(1);
        // A new access may only start while there is room for its result.
        state_s  = (count_s == FULL) ? ST_HOLD : ST_WAIT;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end

      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + ptr_t'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
    end
  end

  // Control state, fetch PC, occupancy and FIFO pointers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r    <= ST_WAIT;
      wcnt_r     <= wcnt_t'(0);
      fetch_pc_r <= RESET_PC;
      count_r    <= cnt_t'(0);
      rd_ptr_r   <= ptr_t'(0);
      wr_ptr_r   <= ptr_t'(0);
    end else begin
      state_r    <= state_s;
      wcnt_r     <= wcnt_s;
      fetch_pc_r <= fetch_pc_s;
      count_r    <= count_s;
      rd_ptr_r   <= rd_ptr_s;
      wr_ptr_r   <= wr_ptr_s;
    end
  end

  // FIFO storage; MemData is sampled only on capture edges.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= 32'h0000_0000;
      end
    end else if (capture_s) begin
      instr_mem_r[wr_ptr_r] <= MemData;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
    end
  end

  // Head outputs come from registered storage and read as zero when empty.
  always_comb begin
    if (valid_s) begin
      Instr   = instr_mem_r[rd_ptr_r];
      InstrPC = pc_mem_r[rd_ptr_r];
    end else begin
      Instr   = 32'h0000_0000;
      InstrPC = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer. A behavioural memory returns X
// until an address has been stable across one clock edge. Expected
// deliveries are queued by the stimulus and popped by a monitor on each
// consumed FIFO head.

module tb_imem_fetch_sequencer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0000_0000;
  logic        InstrReady = 1'b0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [2:0]  Count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int pop_cnt = 0;
  int pops_before;

  logic [63:0] exp_q[$];
  logic [31:0] prev_addr;

  imem_fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_CYCLES(2),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .MemAddr   (MemAddr),
    .MemData   (MemData),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .InstrReady(InstrReady),
    .InstrValid(InstrValid),
    .Instr     (Instr),
    .InstrPC   (InstrPC),
    .Count     (Count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_f = 32'h3408_0032;
      32'h0000_0004: mem_f = 32'hac08_0000;
      32'h0000_0010: mem_f = 32'h3408_001e;
      32'h0000_0190: mem_f = 32'hac09_0054;
      32'h0000_01A0: mem_f = 32'hac08_0058;
      32'hF000_0000: mem_f = 32'h8c08_0000;
      default:       mem_f = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory data is only trustworthy once the address has been held over an edge.
  always @(posedge CLK) prev_addr <= MemAddr;
  assign MemData = (MemAddr == prev_addr) ? mem_f(MemAddr) : 32'hxxxx_xxxx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem_f(pc)});
  endtask

  // Scoreboard: every head consumed by the core must match the next queued entry.
  always @(negedge CLK) begin
    logic [63:0] e;
    if (Reset_L && InstrValid && InstrReady && !Redirect) begin
      total_cnt++;
      assert (exp_q.size() != 0) begin
        pass_cnt++;
        e = exp_q.pop_front();
        check("pop_pc", InstrPC, e[63:32]);
        check("pop_instr", Instr, e[31:0]);
        pop_cnt++;
      end else begin
        fail_cnt++;
        $error("FAIL pop_unexpected: observed PC %h expected no delivery", InstrPC);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_count", 32'(Count), 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc", InstrPC, 32'h0);
    check("rst_addr", MemAddr, 32'h0);

    // Streaming after reset release with the core always ready
    push_pc(32'h0); push_pc(32'h4);
    InstrReady = 1'b1;
    Reset_L = 1'b1;
    step();
    check("lat_valid_e1", 32'(InstrValid), 32'd0);
    check("lat_addr_e1", MemAddr, 32'h0);
    step();
    check("lat_valid_e2", 32'(InstrValid), 32'd1);
    check("first_pc", InstrPC, 32'h0);
    check("first_instr", Instr, 32'h3408_0032);
    check("first_addr", MemAddr, 32'h4);
    check("first_count", 32'(Count), 32'd1);
    step();
    check("drain_count", 32'(Count), 32'd0);
    step();
    check("second_pc", InstrPC, 32'h4);
    check("second_instr", Instr, 32'hac08_0000);
    step();
    InstrReady = 1'b0;

    // Fill to full with the core stalled
    Reset_L = 1'b0;
    step();
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_pc(32'(i * 4));
    Reset_L = 1'b1;
    repeat (8) step();
    check("full_count", 32'(Count), 32'd4);
    check("full_addr", MemAddr, 32'h10);
    check("full_head", InstrPC, 32'h0);
    repeat (3) step();
    check("hold_count", 32'(Count), 32'd4);
    check("hold_addr", MemAddr, 32'h10);
    InstrReady = 1'b1;
    step();
    InstrReady = 1'b0;
    check("pop1_head", InstrPC, 32'h4);
    check("pop1_count", 32'(Count), 32'd3);
    repeat (2) step();
    check("refill_count", 32'(Count), 32'd4);
    check("refill_addr", MemAddr, 32'h14);
    InstrReady = 1'b1;
    repeat (4) step();
    InstrReady = 1'b0;
    check("drain4_count", 32'(Count), 32'd1);
    check("drain4_head", InstrPC, 32'h14);

    // Redirect with one entry buffered and an access half done
    Redirect = 1'b1; RedirectPC = 32'h0000_0190;
    step();
    Redirect = 1'b0;
    check("redir_count", 32'(Count), 32'd0);
    check("redir_valid", 32'(InstrValid), 32'd0);
    check("redir_addr", MemAddr, 32'h190);
    exp_q.delete();
    push_pc(32'h190);
    repeat (2) step();
    check("redir_vld2", 32'(InstrValid), 32'd1);
    check("redir_pc", InstrPC, 32'h190);
    check("redir_instr", Instr, 32'hac09_0054);
    check("redir_cnt2", 32'(Count), 32'd1);

    // Overflow vector redirect racing a pop
    Redirect = 1'b1; RedirectPC = 32'hF000_0000; InstrReady = 1'b1;
    step();
    Redirect = 1'b0; InstrReady = 1'b0;
    check("ovf_count", 32'(Count), 32'd0);
    check("ovf_valid", 32'(InstrValid), 32'd0);
    check("ovf_addr", MemAddr, 32'hF000_0000);
    exp_q.delete();
    push_pc(32'hF000_0000);
    repeat (2) step();
    check("ovf_pc", InstrPC, 32'hF000_0000);
    check("ovf_instr", Instr, 32'h8c08_0000);

    // Misaligned redirect target
    Redirect = 1'b1; RedirectPC = 32'h0000_01A3;
    step();
    Redirect = 1'b0;
    check("align_addr", MemAddr, 32'h1A0);
    check("align_count", 32'(Count), 32'd0);
    exp_q.delete();
    push_pc(32'h1A0);
    repeat (2) step();
    check("align_pc", InstrPC, 32'h1A0);
    check("align_instr", Instr, 32'hac08_0058);

    // Asynchronous reset mid-access with three entries buffered
    repeat (5) step();
    check("pre_rst_count", 32'(Count), 32'd3);
    Reset_L = 1'b0;
    #1;
    check("arst_count", 32'(Count), 32'd0);
    check("arst_valid", 32'(InstrValid), 32'd0);
    check("arst_instr", Instr, 32'h0);
    check("arst_pc", InstrPC, 32'h0);
    check("arst_addr", MemAddr, 32'h0);
    step();
    exp_q.delete();
    for (int i = 0; i < 40; i++) push_pc(32'(i * 4));
    Reset_L = 1'b1;
    InstrReady = 1'b1;
    repeat (2) step();
    check("post_rst_pc", InstrPC, 32'h0);
    check("post_rst_instr", Instr, 32'h3408_0032);

    // Long run with the core alternating ready, crossing pointer wrap
    pops_before = pop_cnt;
    for (int i = 0; i < 60; i++) begin
      InstrReady = (i % 2 == 0);
      step();
    end
    InstrReady = 1'b0;
    check("long_run_enough_pops", 32'((pop_cnt - pops_before) > 2 * DEPTH), 32'd1);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Fetch controller that sequences reads from the read-only instruction memory and buffers fetched words for the processor core.
- The instruction memory is combinational with a read time of 20 ns, so the block holds each address for WAIT_CYCLES clocks, captures the data, and pushes {PC, instruction} into a small show-ahead FIFO.
- The core pops instructions from the FIFO and redirects fetch on taken branches, jumps, jr/jal and the overflow exception vector (0xF0000000).

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- WAIT_CYCLES, 2, clocks the address is held before MemData is sampled (>=1; 2 covers T_rd=20 ns at a 10 ns clock).
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- CLK  input  1  single clock, rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- MemAddr  output  32  address driven to instruction memory; held stable for the whole access.
- MemData  input  32  instruction memory read data.
- Redirect  input  1  core requests fetch restart at RedirectPC (single-cycle pulse).
- RedirectPC  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
- InstrReady  input  1  core pops the FIFO head this cycle.
- InstrValid  output  1  FIFO head is valid.
- Instr  output  32  FIFO head instruction word.
- InstrPC  output  32  PC of the FIFO head.
- Count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, Reset_L=0):
  - fetchPC=RESET_PC, MemAddr=RESET_PC.
  - FIFO empty; Count=0, InstrValid=0, Instr=0, InstrPC=0.
  - Wait counter=0; state=WAIT.
- State HOLD (FIFO full, Count==DEPTH, no access in flight):
  - MemAddr=fetchPC; no capture.
  - Moves to WAIT with counter=0 on the edge where a pop occurs.
- State WAIT:
  - MemAddr=fetchPC; the counter increments each edge.
  - On the edge where counter==WAIT_CYCLES-1, MemData is written with fetchPC into the FIFO tail, fetchPC += 4 (mod 2^32; 0xFFFFFFFC wraps to 0), and the counter is cleared.
  - After that capture the block stays in WAIT if the post-edge Count<DEPTH, otherwise it goes to HOLD.
- Access rules:
  - At most one access is in flight.
  - An access starts only when Count<DEPTH, so a capture never finds the FIFO full.
- Throughput and latency:
  - One instruction per WAIT_CYCLES clocks.
  - Latency from reset release or redirect to InstrValid=1 is WAIT_CYCLES rising edges.
- Pop:
  - When InstrValid & InstrReady, the head advances at the edge.
  - InstrReady while InstrValid=0 is ignored.
  - Capture and pop on the same edge leaves Count unchanged.
- Redirect (sampled at the edge, highest priority):
  - Flushes the FIFO: Count=0 and InstrValid=0 after the edge.
  - Aborts any in-flight access with no capture; any pop in the same cycle is discarded.
  - Sets fetchPC={RedirectPC[31:2],2'b00} and enters WAIT with counter=0.
  - MemAddr shows the new PC in the cycle after the edge.
  - Back-to-back redirects: the last one wins.
- FIFO:
  - Read/write pointers wrap modulo DEPTH.
  - Instr/InstrPC are driven from registered storage at the read pointer, not directly from MemData.
- MemData is sampled only on capture edges; X on MemData at other times (the memory default for unmapped addresses) must not propagate.
- Reset asserted mid-access or mid-redirect: all state returns to reset values immediately; no partial capture.

Test Plan:
- Reset release, RESET_PC=0, WAIT_CYCLES=2, InstrReady=1:
  - InstrValid rises after the 2nd edge with InstrPC=0x00, Instr=0x34080032.
  - Next delivery is PC 0x04 / 0xac080000 two cycles later.
  - MemAddr never changes within an access.
- InstrReady=0 from reset:
  - FIFO fills with PC 0x00, 0x04, 0x08, 0x0C; Count=4, state HOLD, MemAddr=0x10, no further capture.
  - After a single pop, head becomes 0x04 and PC 0x10 / 0x3408001e is captured 2 edges later.
- Redirect pulse with RedirectPC=0x190 while entries are buffered and an access is half-complete:
  - Next edge: Count=0, InstrValid=0, MemAddr=0x190.
  - Two edges later: head is PC 0x190 / 0xac090054; the aborted word is never delivered.
- Redirect to 0xF0000000 (overflow vector) simultaneous with InstrReady=1 on a valid head:
  - Pop is discarded.
  - Head becomes PC 0xF0000000 / 0x8c080000.
- Redirect with RedirectPC=0x1A3:
  - Fetch starts at 0x1A0, delivering 0xac080058.
- Reset_L pulsed low mid-WAIT with FIFO at Count=3:
  - Outputs are immediately zero/invalid.
  - After release, first delivery is PC 0x00 / 0x34080032.
- Long run with InstrReady toggling 1/0 over more than 2·DEPTH instructions:
  - PC sequence is contiguous, with no duplicates or drops across pointer wrap.
